regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-back arbiter and sequencer for the single write port of the 10-entry TinyEncrypt register file. It accepts write beats from three requesters (ALU result, load unit, round-key unit) over valid/ready handshakes, supports locked multi-beat bursts (e.g. a v0/v1 pair), and drives the registered write address, data and enable. Its `wa` output feeds the register file's 4-to-10 write-enable decoder. Illegal addresses are rejected here, before they reach the decoder.

## Interface

Parameters:
- `DW`, default 32: register data width.
- `NREG`, default 10: number of registers; legal addresses are 0..NREG-1.

Ports:
- `clk` in 1: the single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 3: per-requester beat valid.
- `req_last` in 3: final beat of a burst; 1 marks a single-beat write.
- `req_addr` in 12: requester i is at bits [4i+3:4i].
- `req_data` in 3*DW: requester i is at bits [DW*i+DW-1:DW*i].
- `req_ready` out 3: combinational; at most one bit set.
- `wa` out 4: registered write address to the decoder.
- `wd` out DW: registered write data.
- `we` out 1: registered write enable.
- `grant_id` out 2: requester index of the beat currently presented on `wa`/`wd`/`bad_addr`.
- `bad_addr` out 1: one-cycle pulse when an accepted beat had address >= NREG.

## Operation

**Handshake**
- A beat transfers when `req_valid[i] & req_ready[i]`.
- At most one beat transfers per cycle.
- A requester holds `valid`, `addr`, `data` and `last` stable until its beat transfers.
- `req_ready` is 0 for every requester when none is eligible.

**FSM, state IDLE**
- The winner is chosen among valid requesters by the priority rule (see Configuration). `req_ready[winner]` = 1.
- On a transfer with `last` = 1: stay in IDLE and set `ptr` to the winner.
- On a transfer with `last` = 0: store the winner as `owner` and go to LOCK.

**FSM, state LOCK**
- `req_ready[owner]` = `req_valid[owner]`. All other requesters see ready = 0, whatever their valid.
- If the owner drops valid, the FSM waits in LOCK indefinitely. There is no timeout.
- A transfer with `last` = 1 returns to IDLE and sets `ptr` to `owner`.

**Write-back**
- An accepted beat with addr < NREG gives, on the next cycle: `we` = 1, `wa` = addr, `wd` = data, `grant_id` = requester index.
- An accepted beat with addr >= NREG (10..15) is consumed, and the burst/FSM advance normally. Next cycle: `we` = 0, `bad_addr` = 1, `grant_id` = index, and `wa`/`wd` keep their previous values.
- A cycle with no transfer gives, next cycle: `we` = 0 and `bad_addr` = 0, with `wa`, `wd` and `grant_id` held.

**Reset**
- Reset applies in any state, including mid-burst; the burst is abandoned.
- Next cycle: state IDLE, `ptr` = 2 (requester 0 highest priority), `owner` = 0.
- Next cycle outputs: `we` = 0, `wa` = 0, `wd` = 0, `grant_id` = 0, `bad_addr` = 0.
- While `reset` is high, `req_ready` = 0.

## Timing

- Latency is 1 cycle from handshake to `we`/`bad_addr`.
- Throughput is one beat per cycle, including back-to-back beats from different requesters in IDLE.
- The `ptr` update takes effect for the arbitration in the cycle after the final beat.
- `req_ready` is combinational from `req_valid`, the state and `ptr`. There is no combinational path from `req_data` or `req_addr`.
- A single-beat write from requester A followed in the next cycle by a beat from B needs no bubble.

## Configuration

Macro `REGFILE_WB_RR_EN`:
- **Defined:** round-robin. Search starts at `(ptr+1) mod 3` and takes the first valid requester in ascending order with wrap-around.
- **Undefined:** fixed priority 0 > 1 > 2. `ptr` is not implemented, and all other behaviour, including burst lock, is identical.

## Test plan

1. **Reset values.** Assert `reset` for 2 cycles with all `req_valid` = 3'b111. Require: `req_ready` = 0, and `we`/`wa`/`wd`/`grant_id`/`bad_addr` all 0. After release, requester 0 is granted first.
2. **Round robin (`REGFILE_WB_RR_EN`).** All three requesters hold single beats to addr 1, 2, 3 with data 0xA1, 0xB2, 0xC3. Require writes on consecutive cycles in order 0, 1, 2 (`wa` 1, 2, 3). If requester 0 immediately re-requests, it is served after 2. With the macro undefined and requester 0 holding valid, requester 0 wins every cycle.
3. **Burst lock.** Requester 1 sends 3 beats to addr 4, 5, 6 (`last` on the 3rd) while requester 0 is valid throughout. Require three consecutive `we` pulses with `grant_id` = 1. Requester 0's `req_ready` stays 0 until the cycle after requester 1's last beat transfers.
4. **Owner stall.** Requester 2 drops valid for 3 cycles mid-burst. Require `we` = 0, no other requester granted, and the burst resuming when valid returns.
5. **Illegal address.** Requester 0 sends addr 4'd12, data 0xDEAD. Require the beat consumed (ready = 1), next-cycle `we` = 0, `bad_addr` = 1 for one cycle, and `wa`/`wd` unchanged. A following beat to addr 9 writes `wa` = 9.
6. **Reset mid-burst.** Pulse `reset` after beat 1 of a 3-beat burst from requester 2. Require the FSM to return to IDLE. With requesters 0 and 2 both valid afterwards, requester 0 is granted.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-back arbiter and sequencer for the single write port of the
//   10-entry register file. Three requesters (0 = ALU, 1 = load unit,
//   2 = round-key unit) present write beats over valid/ready handshakes.
//   A beat with last = 0 locks the port to that requester until its
//   last beat. Accepted beats appear one cycle later on the registered
//   write port. Beats addressed at or above NREG are consumed but raise
//   bad_addr instead of we, so the write-enable decoder never sees them.
//
//   Build option: define REGFILE_WB_RR_EN for round-robin arbitration
//   between bursts; otherwise fixed priority 0 > 1 > 2.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   req_valid  in   [2:0]      per-requester beat valid
//   req_last   in   [2:0]      final beat of a burst
//   req_addr   in   [11:0]     requester i at [4i+3:4i]
//   req_data   in   [3*DW-1:0] requester i at [DW*i+DW-1:DW*i]
//   req_ready  out  [2:0]      combinational, one-hot or zero
//   wa         out  [3:0]      registered write address
//   wd         out  [DW-1:0]   registered write data
//   we         out             registered write enable
//   grant_id   out  [1:0]      requester of the beat on wa/wd/bad_addr
//   bad_addr   out             pulse: accepted beat had addr >= NREG
//
// state  | meaning
// IDLE   | arbitrate among valid requesters every cycle
// LOCK   | burst in progress, only owner may transfer
module regfile_wb_arbiter #(
   parameter int DW   = 32,
   parameter int NREG = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [2:0]      req_valid,
   input  logic [2:0]      req_last,
   input  logic [11:0]     req_addr,
   input  logic [3*DW-1:0] req_data,
   output logic [2:0]      req_ready,
   output logic [3:0]      wa,
   output logic [DW-1:0]   wd,
   output logic            we,
   output logic [1:0]      grant_id,
   output logic            bad_addr
);

   typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [1:0]      owner_q, owner_d;
   logic [1:0]      win;
   logic            win_vld;
   logic [1:0]      sel;
   logic            xfer;
   logic [3:0]      sel_addr;
   logic [DW-1:0]   sel_data;
   logic            sel_last;

   logic            we_q, we_d;
   logic            bad_q, bad_d;
   logic [3:0]      wa_q, wa_d;
   logic [DW-1:0]   wd_q, wd_d;
   logic [1:0]      gid_q, gid_d;

`ifdef REGFILE_WB_RR_EN
   logic [1:0]      ptr_q, ptr_d;
   logic [1:0]      start;
   logic [2:0]      idx;

   // Walk the search order from lowest to highest priority so that the
   // last hit (the first requester after ptr) wins.
   always_comb begin
      win     = 2'd0;
      win_vld = 1'b0;
      idx     = 3'd0;
      start   = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
      for (int k = 2; k >= 0; k--) begin
         idx = {1'b0, start} + 3'(k);
         if (idx >= 3'd3) idx = idx - 3'd3;
         if (req_valid[idx[1:0]]) begin
            win     = idx[1:0];
            win_vld = 1'b1;
         end
      end
   end
`else
   always_comb begin
      win     = 2'd0;
      win_vld = 1'b1;
      if (req_valid[0])      win = 2'd0;
      else if (req_valid[1]) win = 2'd1;
      else if (req_valid[2]) win = 2'd2;
      else                   win_vld = 1'b0;
   end
`endif

   // Ready depends only on valid, state, owner and ptr; the beat mux
   // below is kept off this path.
   always_comb begin
      req_ready = 3'b000;
      sel       = (state_q == S_LOCK) ? owner_q : win;
      if (!reset) begin
         if (state_q == S_LOCK) begin
            case (owner_q)
               2'd0:    req_ready[0] = req_valid[0];
               2'd1:    req_ready[1] = req_valid[1];
               default: req_ready[2] = req_valid[2];
            endcase
         end else if (win_vld) begin
            case (win)
               2'd0:    req_ready[0] = 1'b1;
               2'd1:    req_ready[1] = 1'b1;
               default: req_ready[2] = 1'b1;
            endcase
         end
      end
   end

   assign xfer = |(req_valid & req_ready);

   always_comb begin
      sel_addr = req_addr[3:0];
      sel_data = req_data[DW-1:0];
      sel_last = req_last[0];
      case (sel)
         2'd1: begin
            sel_addr = req_addr[7:4];
            sel_data = req_data[2*DW-1:DW];
            sel_last = req_last[1];
         end
         2'd2: begin
            sel_addr = req_addr[11:8];
            sel_data = req_data[3*DW-1:2*DW];
            sel_last = req_last[2];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
`ifdef REGFILE_WB_RR_EN
      ptr_d   = ptr_q;
`endif
      we_d    = 1'b0;
      bad_d   = 1'b0;
      wa_d    = wa_q;
      wd_d    = wd_q;
      gid_d   = gid_q;
      if (xfer) begin
         gid_d = sel;
         if (int'(sel_addr) < NREG) begin
            we_d = 1'b1;
            wa_d = sel_addr;
            wd_d = sel_data;
         end else begin
            bad_d = 1'b1;
         end
         if (state_q == S_IDLE) begin
            if (sel_last) begin
`ifdef REGFILE_WB_RR_EN
               ptr_d = win;
`endif
            end else begin
               owner_d = win;
               state_d = S_LOCK;
            end
         end else if (sel_last) begin
            state_d = S_IDLE;
`ifdef REGFILE_WB_RR_EN
            ptr_d   = owner_q;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         owner_q <= 2'd0;
`ifdef REGFILE_WB_RR_EN
         ptr_q   <= 2'd2;
`endif
         we_q    <= 1'b0;
         bad_q   <= 1'b0;
         wa_q    <= 4'd0;
         wd_q    <= '0;
         gid_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
`ifdef REGFILE_WB_RR_EN
         ptr_q   <= ptr_d;
`endif
         we_q    <= we_d;
         bad_q   <= bad_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         gid_q   <= gid_d;
      end
   end

   assign we       = we_q;
   assign bad_addr = bad_q;
   assign wa       = wa_q;
   assign wd       = wd_q;
   assign grant_id = gid_q;

endmodule
